spike_rate_decoder: RTL
=======================

# spike_rate_decoder

Converts the binary spike train produced by a lif_neuron back into numeric values by counting spikes over fixed, back-to-back observation windows. It sits downstream of a neuron's spike_output and is the decode end of the rate-coding scheme. Each completed window yields a spike count and, optionally, a time-to-first-spike value, delivered through a valid/ready handshake to the consumer (readout logic or the next layer's synaptic_input).

## Interface
- WINDOW_CYCLES, 16: length of one observation window in clock cycles; legal values are ≥ 2.
- COUNT_WIDTH, 8: width of rate_out; matches the neuron MEMBRANE_POTENTIAL_WIDTH.
- TTFS_WIDTH, $clog2(WINDOW_CYCLES+1): width of ttfs_out.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- enable  input  1  1 = decode windows continuously; 0 = abort and idle.
- spike_in  input  1  spike train; each cycle at 1 counts as one spike.
- rate_ready  input  1  consumer accepts the result.
- clear_overrun  input  1  synchronous clear of the overrun flag.
- rate_out  output  COUNT_WIDTH  spike count of the last completed window.
- ttfs_out  output  TTFS_WIDTH  offset of the first spike within that window; WINDOW_CYCLES if the window had no spike.
- rate_valid  output  1  result pending.
- overrun  output  1  sticky; a completed result was dropped.

## Operation
- States:
  - IDLE: enable=0; window counter, spike accumulator and first-spike register held at 0.
  - COUNT: a window is in progress.
- IDLE→COUNT: on the first edge that samples enable=1. That cycle is window offset 0.
- COUNT→IDLE: on any edge that samples enable=0. The partial window is discarded and no result is produced. The output register and rate_valid are unaffected.
- In COUNT, offset runs 0..WINDOW_CYCLES-1 and wraps to 0 with no gap. The next window starts on the edge right after the last offset.
- Accumulator:
  - Adds spike_in each cycle.
  - Saturates at 2^COUNT_WIDTH-1 and never wraps.
  - At the last offset, the spike on that cycle is included in the result.
- First-spike register:
  - Loaded with the current offset on the first spike_in=1 of the window.
  - Initialised to WINDOW_CYCLES at window start.
- Window completion (edge after the last offset):
  - If rate_valid=0, or rate_valid=1 with rate_ready=1: load rate_out and ttfs_out, and set rate_valid=1.
  - If rate_valid=1 with rate_ready=0: hold the old result, drop the new one, and set overrun=1.
- Handshake:
  - A transfer occurs on an edge with rate_valid=1 and rate_ready=1.
  - rate_valid clears after a transfer unless a new result loads on the same edge.
  - rate_out and ttfs_out are stable while rate_valid=1 and rate_ready=0.
- Overrun:
  - Cleared by clear_overrun=1.
  - If a set and a clear happen on the same edge, the set wins.
- Reset (asynchronous, any time, including mid-window): state=IDLE; rate_out=0, ttfs_out=0, rate_valid=0, overrun=0; all counters cleared.

## Timing
- If enable is sampled 1 at edge E0, window offsets occupy cycles E0..E0+WINDOW_CYCLES-1.
- The result is registered at edge E0+WINDOW_CYCLES; rate_valid is high in the cycle after that edge.
- In steady state, one result is produced every WINDOW_CYCLES cycles.
- rate_ready→rate_valid has a one-edge turnaround; rate_ready has no combinational path to any output.
- All outputs are registered.

## Configuration
- SPIKE_DECODER_TTFS_EN defined:
  - The first-spike register is built.
  - ttfs_out reports the first-spike offset as described above.
- SPIKE_DECODER_TTFS_EN undefined:
  - The first-spike logic is removed.
  - ttfs_out stays in the port list but is tied to 0.
  - rate_out, rate_valid and overrun behave identically.

## Test plan
Defaults: WINDOW_CYCLES=16, COUNT_WIDTH=8, SPIKE_DECODER_TTFS_EN defined.
- Reset with reset_n=0 while spike_in toggles -> all outputs 0. Release, then enable=1 with spike_in=1 every cycle and rate_ready=1 -> rate_valid pulses 1 cycle at E0+16+, rate_out=16, ttfs_out=0; repeats every 16 cycles.
- Spikes only at offsets 5 and 9 -> rate_out=2, ttfs_out=5. An all-zero window -> rate_out=0, ttfs_out=16.
- rate_ready=0 across two complete windows (counts 3 then 7) -> rate_out stays 3 and overrun=1. Raise rate_ready -> 3 transfers and rate_valid drops. clear_overrun -> overrun=0.
- Window completes on the same edge as an accepted transfer -> new value loads, rate_valid stays 1, overrun stays 0.
- COUNT_WIDTH=3 with spikes every cycle -> rate_out=7 (saturated, not 0).
- enable dropped at offset 8 and raised again 3 cycles later -> no result from the aborted window; the next result counts only spikes from the new E0.
- reset_n asserted at offset 10 with rate_valid=1 -> all outputs 0 immediately, with no dependence on clk.
- Rebuild without SPIKE_DECODER_TTFS_EN -> ttfs_out=0 in every scenario; rate_out values unchanged.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//
// Decodes a rate-coded spike train back into numbers. Spikes are counted over
// fixed, back-to-back windows of WINDOW_CYCLES cycles. Each completed window
// yields a saturating spike count and, optionally, a time-to-first-spike
// offset. Results are delivered through a valid/ready handshake.
//
// Optional feature macro: SPIKE_DECODER_TTFS_EN
//   defined   : the first-spike register is built and ttfs_out reports the
//               offset of the first spike in the window (WINDOW_CYCLES if the
//               window had no spike).
//   undefined : the first-spike logic is removed and ttfs_out is tied to 0.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   1 = decode windows continuously, 0 = abort and idle
//   spike_in      in   spike train, one spike per cycle at 1
//   rate_ready    in   consumer accepts the pending result
//   clear_overrun in   synchronous clear of the sticky overrun flag
//   rate_out      out  spike count of the last completed window
//   ttfs_out      out  first-spike offset of that window
//   rate_valid    out  result pending
//   overrun       out  sticky, a completed result was dropped

module spike_rate_decoder #(
    parameter int unsigned WINDOW_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned TTFS_WIDTH    = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   spike_in,
    input  logic                   rate_ready,
    input  logic                   clear_overrun,
    output logic [COUNT_WIDTH-1:0] rate_out,
    output logic [TTFS_WIDTH-1:0]  ttfs_out,
    output logic                   rate_valid,
    output logic                   overrun
);

    localparam int unsigned OffW = $clog2(WINDOW_CYCLES);
    localparam logic [OffW-1:0] LastOff = OffW'(WINDOW_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StCount
    } state_e;

    state_e                 state_q, state_d;
    logic [OffW-1:0]        offset_q, offset_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    // Set on the edge that samples the last offset; the result is registered
    // on the following edge, which is also offset 0 of the next window.
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] rate_q, rate_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    logic                   win_start;
    logic [COUNT_WIDTH-1:0] acc_base;
    logic                   load_result;
    logic                   overrun_set;

`ifdef SPIKE_DECODER_TTFS_EN
    localparam logic [TTFS_WIDTH-1:0] NoSpike = TTFS_WIDTH'(WINDOW_CYCLES);

    logic [TTFS_WIDTH-1:0] first_q, first_d;
    logic [TTFS_WIDTH-1:0] ttfs_q, ttfs_d;
    logic [TTFS_WIDTH-1:0] first_base;
`endif

    // Window sampling: counters, accumulator and first-spike tracking.
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        // Offset 0 is either the first enabled edge or the wrap edge; the
        // previous count in acc_q is still visible to the result stage there.
        win_start = (state_q == StIdle) || (offset_q == '0);
        acc_base  = win_start ? '0 : acc_q;
`ifdef SPIKE_DECODER_TTFS_EN
        first_d    = first_q;
        first_base = win_start ? NoSpike : first_q;
`endif

        if (enable) begin
            state_d  = StCount;
            acc_d    = (spike_in && (acc_base != '1)) ? acc_base + COUNT_WIDTH'(1)
                                                      : acc_base;
            offset_d = (offset_q == LastOff) ? '0 : offset_q + OffW'(1);
            done_d   = (offset_q == LastOff);
`ifdef SPIKE_DECODER_TTFS_EN
            first_d  = (spike_in && (first_base == NoSpike)) ? TTFS_WIDTH'(offset_q)
                                                            : first_base;
`endif
        end else begin
            // Abort: partial window is discarded, counters held at 0.
            state_d  = StIdle;
            offset_d = '0;
            acc_d    = '0;
`ifdef SPIKE_DECODER_TTFS_EN
            first_d  = '0;
`endif
        end
    end

    // Result register, handshake and overrun.
    always_comb begin
        rate_d      = rate_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        load_result = done_q && (!valid_q || rate_ready);
        overrun_set = done_q && valid_q && !rate_ready;
`ifdef SPIKE_DECODER_TTFS_EN
        ttfs_d      = ttfs_q;
`endif

        if (load_result) begin
            rate_d  = acc_q;
            valid_d = 1'b1;
`ifdef SPIKE_DECODER_TTFS_EN
            ttfs_d  = first_q;
`endif
        end else if (valid_q && rate_ready) begin
            valid_d = 1'b0;
        end

        // Set has priority over clear.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            offset_q  <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            rate_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            rate_q    <= rate_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SPIKE_DECODER_TTFS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q <= '0;
            ttfs_q  <= '0;
        end else begin
            first_q <= first_d;
            ttfs_q  <= ttfs_d;
        end
    end

    assign ttfs_out = ttfs_q;
`else
    assign ttfs_out = '0;
`endif

    assign rate_out   = rate_q;
    assign rate_valid = valid_q;
    assign overrun    = overrun_q;

endmodule
